// File: rtl/num_comparator.sv
// ---------------------------------------------------------------------------
// num_comparator
//
// Registered magnitude comparator for two WIDTH-bit operands. Each valid
// sample produces one-hot less/equal/greater flags one cycle later, using
// either unsigned or two's-complement interpretation chosen per sample.
// Three saturating counters record how many valid samples fell into each
// outcome, for observability.
//
// Parameters:
//   WIDTH      operand width in bits (1..32)
//   CNT_WIDTH  width of each outcome counter (1..32)
//
// Ports:
//   sys_clk      in   system clock, all state changes on the rising edge
//   sys_rst      in   synchronous active-high reset, overrides everything
//   num1, num2   in   operands (WIDTH bits)
//   in_valid     in   operands valid this cycle
//   signed_mode  in   0 = unsigned, 1 = two's-complement; used with in_valid
//   cnt_clr      in   synchronous clear of all counters (wins over counting)
//   less         out  registered num1 <  num2
//   equal        out  registered num1 == num2
//   greater      out  registered num1 >  num2
//   out_valid    out  flags were refreshed by a valid sample last cycle
//   less_cnt     out  count of valid samples with num1 <  num2
//   equal_cnt    out  count of valid samples with num1 == num2
//   greater_cnt  out  count of valid samples with num1 >  num2
// ---------------------------------------------------------------------------
module num_comparator #(
    parameter int WIDTH     = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    input  logic                 in_valid,
    input  logic                 signed_mode,
    input  logic                 cnt_clr,
    output logic                 less,
    output logic                 equal,
    output logic                 greater,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] less_cnt,
    output logic [CNT_WIDTH-1:0] equal_cnt,
    output logic [CNT_WIDTH-1:0] greater_cnt
);

    // Mask selecting the operand MSB, which is the sign in signed mode.
    localparam logic [WIDTH-1:0]     SIGN_BIT = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic                 r_less;
    logic                 r_equal;
    logic                 r_greater;
    logic                 r_outValid;
    logic [CNT_WIDTH-1:0] r_lessCnt;
    logic [CNT_WIDTH-1:0] r_equalCnt;
    logic [CNT_WIDTH-1:0] r_greaterCnt;

    logic [WIDTH-1:0]     w_bias;
    logic [WIDTH-1:0]     w_key1;
    logic [WIDTH-1:0]     w_key2;
    logic                 w_less;
    logic                 w_equal;
    logic                 w_greater;

    // Signed compare is done by flipping both sign bits and then comparing
    // unsigned: this maps -2^(W-1)..2^(W-1)-1 monotonically onto 0..2^W-1,
    // so a single unsigned comparator serves both modes. Equality does not
    // depend on the mapping, so it uses the raw operands.
    always_comb begin
        w_bias    = '0;
        w_key1    = '0;
        w_key2    = '0;
        w_less    = 1'b0;
        w_equal   = 1'b0;
        w_greater = 1'b0;

        if (signed_mode) begin
            w_bias = SIGN_BIT;
        end
        w_key1    = num1 ^ w_bias;
        w_key2    = num2 ^ w_bias;
        w_less    = (w_key1 < w_key2);
        w_equal   = (num1 == num2);
        w_greater = ~w_less & ~w_equal;
    end

    // Flag register: refreshed only by valid samples, otherwise holds so the
    // last result stays readable; out_valid marks the refresh cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_less     <= 1'b0;
            r_equal    <= 1'b0;
            r_greater  <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= in_valid;
            if (in_valid) begin
                r_less    <= w_less;
                r_equal   <= w_equal;
                r_greater <= w_greater;
            end
        end
    end

    // Outcome counters: the clear takes priority over a coincident sample,
    // and each counter sticks at its maximum instead of wrapping.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || cnt_clr) begin
            r_lessCnt    <= '0;
            r_equalCnt   <= '0;
            r_greaterCnt <= '0;
        end else if (in_valid) begin
            if (w_less && (r_lessCnt != CNT_MAX)) begin
                r_lessCnt <= r_lessCnt + 1'b1;
            end
            if (w_equal && (r_equalCnt != CNT_MAX)) begin
                r_equalCnt <= r_equalCnt + 1'b1;
            end
            if (w_greater && (r_greaterCnt != CNT_MAX)) begin
                r_greaterCnt <= r_greaterCnt + 1'b1;
            end
        end
    end

    assign less        = r_less;
    assign equal       = r_equal;
    assign greater     = r_greater;
    assign out_valid   = r_outValid;
    assign less_cnt    = r_lessCnt;
    assign equal_cnt   = r_equalCnt;
    assign greater_cnt = r_greaterCnt;

endmodule

// File: tb/tb_num_comparator.sv
// ---------------------------------------------------------------------------
// tb_num_comparator
//
// Directed testbench for num_comparator. Two instances share all inputs:
// the main one (WIDTH=2, CNT_WIDTH=16) and a narrow-counter one
// (WIDTH=2, CNT_WIDTH=2) used to observe counter saturation.
// ---------------------------------------------------------------------------
module tb_num_comparator;

    logic        sys_clk;
    logic        sys_rst;
    logic [1:0]  num1;
    logic [1:0]  num2;
    logic        in_valid;
    logic        signed_mode;
    logic        cnt_clr;

    logic        less;
    logic        equal;
    logic        greater;
    logic        out_valid;
    logic [15:0] less_cnt;
    logic [15:0] equal_cnt;
    logic [15:0] greater_cnt;

    logic        satLess;
    logic        satEqual;
    logic        satGreater;
    logic        satOutValid;
    logic [1:0]  satLessCnt;
    logic [1:0]  satEqualCnt;
    logic [1:0]  satGreaterCnt;

    int vectors;
    int miscompares;

    num_comparator #(.WIDTH(2), .CNT_WIDTH(16)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .num1        (num1),
        .num2        (num2),
        .in_valid    (in_valid),
        .signed_mode (signed_mode),
        .cnt_clr     (cnt_clr),
        .less        (less),
        .equal       (equal),
        .greater     (greater),
        .out_valid   (out_valid),
        .less_cnt    (less_cnt),
        .equal_cnt   (equal_cnt),
        .greater_cnt (greater_cnt)
    );

    num_comparator #(.WIDTH(2), .CNT_WIDTH(2)) dutSat (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .num1        (num1),
        .num2        (num2),
        .in_valid    (in_valid),
        .signed_mode (signed_mode),
        .cnt_clr     (cnt_clr),
        .less        (satLess),
        .equal       (satEqual),
        .greater     (satGreater),
        .out_valid   (satOutValid),
        .less_cnt    (satLessCnt),
        .equal_cnt   (satEqualCnt),
        .greater_cnt (satGreaterCnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Advance one rising edge and settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Synchronous reset pulse with all other inputs idle.
    task automatic applyStimulus_reset();
        sys_rst  = 1'b1;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        tick();
        sys_rst  = 1'b0;
    endtask

    // Reset state: all flags, out_valid and counters at zero.
    task automatic test_reset();
        sys_rst     = 1'b1;
        num1        = 2'b00;
        num2        = 2'b00;
        in_valid    = 1'b0;
        signed_mode = 1'b0;
        cnt_clr     = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        vectors++;
        if ({less, equal, greater, out_valid} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got=%b want=0000",
                     {less, equal, greater, out_valid});
        end
        vectors++;
        if ({less_cnt, equal_cnt, greater_cnt} !== 48'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_counters got=%0d/%0d/%0d want=0/0/0",
                     less_cnt, equal_cnt, greater_cnt);
        end
    endtask

    // All 16 unsigned pairs back-to-back; flags checked one cycle later.
    task automatic test_unsigned_sweep();
        logic [2:0] want;
        applyStimulus_reset();
        signed_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                num1     = 2'(i);
                num2     = 2'(j);
                in_valid = 1'b1;
                tick();
                want = {(i < j), (i == j), (i > j)};
                vectors++;
                if ({less, equal, greater, out_valid} !== {want, 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL unsigned_%0d_%0d got=%b want=%b1",
                             i, j, {less, equal, greater, out_valid}, want);
                end
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (less_cnt !== 16'd6 || equal_cnt !== 16'd4 || greater_cnt !== 16'd6) begin
            miscompares++;
            $display("[TB] FAIL sweep_counters got=%0d/%0d/%0d want=6/4/6",
                     less_cnt, equal_cnt, greater_cnt);
        end
    endtask

    // Signed versus unsigned interpretation of the same operand pairs.
    task automatic test_signed();
        logic [1:0] aTab [4];
        logic [1:0] bTab [4];
        logic [2:0] sWant [4];
        logic [2:0] uWant [4];
        aTab[0] = 2'b11; bTab[0] = 2'b01; sWant[0] = 3'b100; uWant[0] = 3'b001;
        aTab[1] = 2'b10; bTab[1] = 2'b11; sWant[1] = 3'b100; uWant[1] = 3'b100;
        aTab[2] = 2'b01; bTab[2] = 2'b10; sWant[2] = 3'b001; uWant[2] = 3'b100;
        aTab[3] = 2'b11; bTab[3] = 2'b11; sWant[3] = 3'b010; uWant[3] = 3'b010;
        applyStimulus_reset();
        for (int m = 1; m >= 0; m--) begin
            for (int k = 0; k < 4; k++) begin
                num1        = aTab[k];
                num2        = bTab[k];
                signed_mode = m[0];
                in_valid    = 1'b1;
                tick();
                vectors++;
                if ({less, equal, greater} !== (m == 1 ? sWant[k] : uWant[k])) begin
                    miscompares++;
                    $display("[TB] FAIL mode%0d_%b_%b got=%b want=%b", m, aTab[k], bTab[k],
                             {less, equal, greater}, (m == 1 ? sWant[k] : uWant[k]));
                end
            end
        end
        in_valid    = 1'b0;
        signed_mode = 1'b0;
    endtask

    // One sample then three idle cycles: out_valid pulses once, state holds.
    // signed_mode is toggled while idle and must have no effect.
    task automatic test_valid_gating();
        applyStimulus_reset();
        num1        = 2'b10;
        num2        = 2'b01;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        tick();
        vectors++;
        if ({less, equal, greater, out_valid} !== 4'b0011) begin
            miscompares++;
            $display("[TB] FAIL gating_sample got=%b want=0011",
                     {less, equal, greater, out_valid});
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            signed_mode = ~signed_mode;
            tick();
            vectors++;
            if ({less, equal, greater, out_valid} !== 4'b0010) begin
                miscompares++;
                $display("[TB] FAIL gating_idle%0d got=%b want=0010",
                         c, {less, equal, greater, out_valid});
            end
            vectors++;
            if (less_cnt !== 16'd0 || equal_cnt !== 16'd0 || greater_cnt !== 16'd1) begin
                miscompares++;
                $display("[TB] FAIL gating_cnt%0d got=%0d/%0d/%0d want=0/0/1",
                         c, less_cnt, equal_cnt, greater_cnt);
            end
        end
        signed_mode = 1'b0;
    endtask

    // Five identical 'less' samples: the 2-bit counter sticks at 3.
    task automatic test_saturation();
        logic [1:0] satWant;
        applyStimulus_reset();
        num1        = 2'b00;
        num2        = 2'b01;
        signed_mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            tick();
            satWant = (k > 3) ? 2'd3 : 2'(k);
            vectors++;
            if (satLessCnt !== satWant) begin
                miscompares++;
                $display("[TB] FAIL sat_less_cnt_%0d got=%0d want=%0d", k, satLessCnt, satWant);
            end
            vectors++;
            if (less_cnt !== 16'(k)) begin
                miscompares++;
                $display("[TB] FAIL wide_less_cnt_%0d got=%0d want=%0d", k, less_cnt, k);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (satLessCnt !== 2'd3 || satEqualCnt !== 2'd0 || satGreaterCnt !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL sat_hold got=%0d/%0d/%0d want=3/0/0",
                     satLessCnt, satEqualCnt, satGreaterCnt);
        end
    endtask

    // cnt_clr together with a valid sample: counters clear, flags update.
    task automatic test_clear_priority();
        applyStimulus_reset();
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        num1 = 2'b00; num2 = 2'b01;
        tick();
        num1 = 2'b01; num2 = 2'b01;
        tick();
        vectors++;
        if (less_cnt !== 16'd1 || equal_cnt !== 16'd1 || greater_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL clr_precount got=%0d/%0d/%0d want=1/1/0",
                     less_cnt, equal_cnt, greater_cnt);
        end
        num1    = 2'b01;
        num2    = 2'b00;
        cnt_clr = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (less_cnt !== 16'd0 || equal_cnt !== 16'd0 || greater_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL clr_counters got=%0d/%0d/%0d want=0/0/0",
                     less_cnt, equal_cnt, greater_cnt);
        end
        vectors++;
        if ({less, equal, greater, out_valid} !== 4'b0011) begin
            miscompares++;
            $display("[TB] FAIL clr_flags got=%b want=0011",
                     {less, equal, greater, out_valid});
        end
    endtask

    // Reset asserted during a valid stream wins; the next sample counts.
    task automatic test_reset_midstream();
        applyStimulus_reset();
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        num1 = 2'b01; num2 = 2'b00;
        tick();
        num1 = 2'b00; num2 = 2'b00;
        tick();
        num1 = 2'b00; num2 = 2'b01;
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        vectors++;
        if ({less, equal, greater, out_valid} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL midrst_flags got=%b want=0000",
                     {less, equal, greater, out_valid});
        end
        vectors++;
        if (less_cnt !== 16'd0 || equal_cnt !== 16'd0 || greater_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_counters got=%0d/%0d/%0d want=0/0/0",
                     less_cnt, equal_cnt, greater_cnt);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({less, equal, greater, out_valid} !== 4'b1001) begin
            miscompares++;
            $display("[TB] FAIL postrst_flags got=%b want=1001",
                     {less, equal, greater, out_valid});
        end
        vectors++;
        if (less_cnt !== 16'd1 || equal_cnt !== 16'd0 || greater_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL postrst_counters got=%0d/%0d/%0d want=1/0/0",
                     less_cnt, equal_cnt, greater_cnt);
        end
    endtask

    // Runs each scenario in turn and prints the summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_unsigned_sweep();
        test_signed();
        test_valid_gating();
        test_saturation();
        test_clear_priority();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/num_comparator.md
Name: num_comparator

Overview:
Registered magnitude comparator for two WIDTH-bit operands. It produces one-hot less/equal/greater flags, with unsigned or two's-complement interpretation selectable per sample. It also keeps saturating per-outcome event counters for observability. It is intended as a leaf datapath block, for example in threshold detection or sort/compare stages, clocked in the system domain.

Parameters:
WIDTH, 2, operand width in bits (legal range 1..32)
CNT_WIDTH, 16, width of each outcome counter (legal range 1..32)

Ports:
sys_clk  input  1  system clock; all state updates on rising edge
sys_rst  input  1  synchronous, active-high reset
num1  input  WIDTH  first operand
num2  input  WIDTH  second operand
in_valid  input  1  operands valid this cycle
signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare; sampled with in_valid
cnt_clr  input  1  synchronous clear of all outcome counters
less  output  1  registered: num1 < num2
equal  output  1  registered: num1 == num2
greater  output  1  registered: num1 > num2
out_valid  output  1  registered: flags updated from a valid sample last cycle
less_cnt  output  CNT_WIDTH  number of valid samples with num1 < num2
equal_cnt  output  CNT_WIDTH  number of valid samples with num1 == num2
greater_cnt  output  CNT_WIDTH  number of valid samples with num1 > num2

Behaviour:
- All state is updated on the rising edge of sys_clk only; there are no combinational input-to-output paths.
- Reset (sys_rst=1 at a rising edge):
  - less, equal, greater, out_valid = 0.
  - All counters = 0.
  - Reset overrides every other input, including a valid sample in the same cycle.
- Latency: a sample accepted at edge N (in_valid=1) has its flags visible after edge N, with out_valid=1 for exactly that cycle.
- Throughput: one sample per cycle, with no back-pressure.
- in_valid=0:
  - out_valid goes to 0 at the next edge.
  - less/equal/greater hold their last values.
  - Counters hold.
- Compare rules:
  - signed_mode=0: operands are unsigned, range 0..2^WIDTH-1.
  - signed_mode=1: operands are two's complement; the MSB is the sign (e.g. WIDTH=2: 2'b11 = -1 < 2'b01 = +1).
  - Equality is independent of mode.
- After the first valid sample, exactly one of less/equal/greater is 1. After reset and before any valid sample, all three are 0.
- Counters:
  - On each valid sample, exactly one counter increments, matching the new flag.
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- cnt_clr=1:
  - All counters go to 0 at the next edge.
  - If in_valid=1 in the same cycle, the clear wins and the sample is not counted; its flags and out_valid still update normally.
- cnt_clr does not affect the flags or out_valid.
- Changes to signed_mode while in_valid=0 have no effect.

Test Plan:
- Exhaustive unsigned sweep, WIDTH=2, signed_mode=0, all 16 (num1,num2) pairs back-to-back:
  - Flags one cycle later match the unsigned comparison, e.g. (00,01) -> less=1; (10,10) -> equal=1; (11,00) -> greater=1.
  - After the sweep: less_cnt=6, equal_cnt=4, greater_cnt=6.
- Signed mode, WIDTH=2:
  - (11,01) -> less=1.
  - (10,11) -> less=1.
  - (01,10) -> greater=1.
  - (11,11) -> equal=1.
  - Same pairs with signed_mode=0 -> greater, less, less, equal.
- Valid gating:
  - Apply a sample, then hold in_valid=0 for 3 cycles.
  - out_valid pulses for 1 cycle only; flags and counters hold.
- Saturation, CNT_WIDTH=2:
  - Apply 5 consecutive samples (00,01) -> less_cnt reaches 3 and stays 3.
- Clear priority:
  - With counters nonzero, assert cnt_clr together with a valid (01,00) sample.
  - All counters read 0 the next cycle; greater=1 and out_valid=1.
- Reset mid-stream:
  - Assert sys_rst during continuous valid samples.
  - The next cycle shows all flags, out_valid and counters at 0.
  - The first sample after release is flagged and counted normally.
